// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with clear, load, enable, saturate option,
// combinational terminal-count flag and registered wrap pulse.
module updown_mod_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter int unsigned      SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic at_max;
  logic at_zero;
  logic sat_mode;

  assign at_max   = (count == MAX_COUNT);
  assign at_zero  = (count == '0);
  assign sat_mode = (SATURATE != 0);
  assign tc       = en & ((up & at_max) | (~up & at_zero));

  // Boundary tests use equality only; count never exceeds MAX_COUNT, so no
  // increment can overflow WIDTH bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
      wrap  <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          count <= count + ONE;
          wrap  <= 1'b0;
        end else if (!sat_mode) begin
          count <= '0;
          wrap  <= 1'b1;
        end else begin
          wrap  <= 1'b0;
        end
      end else begin
        if (!at_zero) begin
          count <= count - ONE;
          wrap  <= 1'b0;
        end else if (!sat_mode) begin
          count <= MAX_COUNT;
          wrap  <= 1'b1;
        end else begin
          wrap  <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench: five counter instances (default, BCD down, saturating, two-digit cascade)
// driven by directed steps and checked against a queued reference model.
module tb_updown_mod_counter;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr  [4];
  logic       load [4];
  logic [3:0] lv   [4];
  logic       en   [4];
  logic       up   [4];
  logic [3:0] cnt  [N];
  logic       tc   [N];
  logic       wrap [N];

  int errors = 0;
  int checks = 0;

  int mcnt [N];
  int maxv [N] = '{15, 9, 15, 9, 9};
  bit satv [N] = '{0, 0, 1, 0, 0};

  typedef struct {
    int idx;
    int c;
    bit w;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  updown_mod_counter u_a (
    .clk(clk), .reset(reset), .clr(clr[0]), .load(load[0]), .load_val(lv[0]),
    .en(en[0]), .up(up[0]), .count(cnt[0]), .tc(tc[0]), .wrap(wrap[0]));
  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(4'd9)) u_b (
    .clk(clk), .reset(reset), .clr(clr[1]), .load(load[1]), .load_val(lv[1]),
    .en(en[1]), .up(up[1]), .count(cnt[1]), .tc(tc[1]), .wrap(wrap[1]));
  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(4'd15), .SATURATE(1)) u_c (
    .clk(clk), .reset(reset), .clr(clr[2]), .load(load[2]), .load_val(lv[2]),
    .en(en[2]), .up(up[2]), .count(cnt[2]), .tc(tc[2]), .wrap(wrap[2]));
  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(4'd9)) u_lo (
    .clk(clk), .reset(reset), .clr(clr[3]), .load(load[3]), .load_val(lv[3]),
    .en(en[3]), .up(up[3]), .count(cnt[3]), .tc(tc[3]), .wrap(wrap[3]));
  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(4'd9)) u_hi (
    .clk(clk), .reset(reset), .clr(clr[3]), .load(load[3]), .load_val(lv[3]),
    .en(tc[3]), .up(up[3]), .count(cnt[4]), .tc(tc[4]), .wrap(wrap[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Controls seen by instance i (the high cascade digit shares the low digit's).
  function automatic int ci(input int i);
    return (i == 4) ? 3 : i;
  endfunction

  function automatic bit model_tc(input int i);
    bit e;
    int c;
    c = ci(i);
    e = (i == 4) ? model_tc(3) : bit'(en[c]);
    return e && ((up[c] && mcnt[i] == maxv[i]) || (!up[c] && mcnt[i] == 0));
  endfunction

  // One clock: check tc, queue expected next state, clock, then drain the queue.
  task automatic step();
    bit   e [N];
    exp_t x;
    #1;
    for (int i = 0; i < N; i++) begin
      e[i] = (i == 4) ? model_tc(3) : bit'(en[i]);
      chk($sformatf("tc%0d", i), 32'(tc[i]), 32'(model_tc(i)));
    end
    for (int i = 0; i < N; i++) begin
      int c;
      c   = ci(i);
      x.idx = i;
      x.c   = mcnt[i];
      x.w   = 1'b0;
      if (clr[c]) x.c = 0;
      else if (load[c]) x.c = (int'(lv[c]) > maxv[i]) ? maxv[i] : int'(lv[c]);
      else if (e[i]) begin
        if (up[c]) begin
          if (mcnt[i] < maxv[i]) x.c = mcnt[i] + 1;
          else if (!satv[i]) begin x.c = 0; x.w = 1'b1; end
        end else begin
          if (mcnt[i] > 0) x.c = mcnt[i] - 1;
          else if (!satv[i]) begin x.c = maxv[i]; x.w = 1'b1; end
        end
      end
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      chk($sformatf("count%0d", x.idx), 32'(cnt[x.idx]), 32'(x.c));
      chk($sformatf("wrap%0d", x.idx), 32'(wrap[x.idx]), 32'(x.w));
      mcnt[x.idx] = x.c;
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      clr[i] = 1'b0; load[i] = 1'b0; lv[i] = '0; en[i] = 1'b0; up[i] = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    #12;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_count%0d", i), 32'(cnt[i]), 0);
      chk($sformatf("rst_wrap%0d", i), 32'(wrap[i]), 0);
    end
    en[1] = 1'b1; up[1] = 1'b0;
    #0.5;
    chk("rst_tc_down", 32'(tc[1]), 1);
    chk("rst_tc_up", 32'(tc[0]), 0);
    en[1] = 1'b0;
    reset = 1'b0;

    // Default counter up and BCD counter down, 17 edges.
    en[0] = 1'b1; up[0] = 1'b1;
    en[1] = 1'b1; up[1] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("bcd_range", 32'(cnt[1] <= 4'd9), 1);
      if (k == 1) begin
        chk("bcd_first", 32'(cnt[1]), 9);
        chk("bcd_first_wrap", 32'(wrap[1]), 1);
      end
      if (k == 15) begin
        chk("a_at15", 32'(cnt[0]), 15);
        chk("a_tc15", 32'(tc[0]), 1);
      end
      if (k == 16) begin
        chk("a_wrap0", 32'(cnt[0]), 0);
        chk("a_wrap_pulse", 32'(wrap[0]), 1);
      end
      if (k == 17) chk("a_after", 32'(cnt[0]), 1);
    end
    idle_all();

    // Saturating counter: load 14, up 3, down 16.
    load[2] = 1'b1; lv[2] = 4'd14;
    step();
    load[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("sat_hi", 32'(cnt[2]), 15);
      chk("sat_hi_wrap", 32'(wrap[2]), 0);
    end
    up[2] = 1'b0;
    for (int k = 0; k < 16; k++) step();
    chk("sat_lo", 32'(cnt[2]), 0);
    idle_all();

    // Priority: clr beats load beats en; loads clamp to MAX_COUNT.
    load[0] = 1'b1; lv[0] = 4'd5;
    step();
    chk("pri_load5", 32'(cnt[0]), 5);
    clr[0] = 1'b1; lv[0] = 4'd3; en[0] = 1'b1;
    step();
    chk("pri_clr", 32'(cnt[0]), 0);
    clr[0] = 1'b0; lv[0] = 4'd12;
    load[1] = 1'b1; lv[1] = 4'd12; en[1] = 1'b1;
    step();
    chk("pri_load12", 32'(cnt[0]), 12);
    chk("clamp9", 32'(cnt[1]), 9);
    idle_all();

    // Async reset mid-cycle.
    load[0] = 1'b1; lv[0] = 4'd6;
    step();
    load[0] = 1'b0; en[0] = 1'b1;
    step();
    chk("pre_rst7", 32'(cnt[0]), 7);
    #2 reset = 1'b1;
    #1;
    chk("async_count", 32'(cnt[0]), 0);
    chk("async_wrap", 32'(wrap[0]), 0);
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    #1 reset = 1'b0;
    step();
    chk("post_rst1", 32'(cnt[0]), 1);
    idle_all();

    // Two-digit BCD cascade, 100 edges.
    en[3] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 99) chk("casc99", 32'({cnt[4], cnt[3]}), 32'h99);
    end
    chk("casc100", 32'({cnt[4], cnt[3]}), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
